// File: rtl/c_incr_ctr.sv
// ============================================================================
// c_incr_ctr: registered modulo up-counter over [MIN_VALUE, MAX_VALUE] with
// load, wrap pulse, at-max flag and sticky range error. Define
// C_INCR_CTR_SAT_EN for saturating mode (holds at MAX_VALUE, no wrap pulse).
// Revision: 1.0
// ============================================================================
`default_nettype none

module c_incr_ctr #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] MIN_VALUE   = '0,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = MIN_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_active,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_incr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_max,
  output logic             o_wrap,
  output logic             o_error
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_error;

  logic             w_at_max;
  logic             w_ge_min;
  logic             w_le_max;
  logic             w_in_range;
  logic [WIDTH-1:0] w_next_incr;
  logic             w_wrap_set;

  assign w_at_max = (r_count == MAX_VALUE);

  // Range bounds at the ends of the encoding are always met; skip the compare
  // so no constant-result comparison is built.
  generate
    if (MIN_VALUE == '0) begin : g_min_zero
      assign w_ge_min = 1'b1;
    end else begin : g_min_cmp
      assign w_ge_min = (i_load_value >= MIN_VALUE);
    end
    if (MAX_VALUE == {WIDTH{1'b1}}) begin : g_max_full
      assign w_le_max = 1'b1;
    end else begin : g_max_cmp
      assign w_le_max = (i_load_value <= MAX_VALUE);
    end
  endgenerate

  assign w_in_range = w_ge_min & w_le_max;

`ifdef C_INCR_CTR_SAT_EN
  assign w_next_incr = w_at_max ? MAX_VALUE : (r_count + 1'b1);
  assign w_wrap_set  = 1'b0;
`else
  assign w_next_incr = w_at_max ? MIN_VALUE : (r_count + 1'b1);
  assign w_wrap_set  = w_at_max;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VALUE;
      r_wrap  <= 1'b0;
      r_error <= 1'b0;
    end else if (!i_active) begin
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_wrap <= 1'b0;
      if (w_in_range) begin
        r_count <= i_load_value;
      end else begin
        r_count <= MIN_VALUE;
        r_error <= 1'b1;
      end
    end else if (i_incr) begin
      r_count <= w_next_incr;
      r_wrap  <= w_wrap_set;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;
  assign o_wrap   = r_wrap;
  assign o_error  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_c_incr_ctr.sv
// ============================================================================
// tb_c_incr_ctr: directed bench with a behavioural range-counter model and a
// per-cycle compare against c_incr_ctr (width 3, range 2..6, reset 2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_c_incr_ctr;

  localparam int C_MIN = 2;
  localparam int C_MAX = 6;
  localparam int C_RST = 2;
  localparam int C_NUM = C_MAX - C_MIN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_value = 3'd0;
  logic       incr = 1'b0;
  logic [2:0] count;
  logic       at_max;
  logic       wrap;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;

  int m_count;
  bit m_wrap;
  bit m_error;

  c_incr_ctr #(
    .WIDTH(3), .MIN_VALUE(3'd2), .MAX_VALUE(3'd6), .RESET_VALUE(3'd2)
  ) dut (
    .clk(clk), .rst(rst), .i_active(active), .i_load(load),
    .i_load_value(load_value), .i_incr(incr), .o_count(count),
    .o_at_max(at_max), .o_wrap(wrap), .o_error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts as an offset within a range of C_NUM values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= C_RST;
      m_wrap  <= 1'b0;
      m_error <= 1'b0;
    end else if (!active) begin
      m_wrap <= 1'b0;
    end else if (load) begin
      m_wrap <= 1'b0;
      if (int'(load_value) >= C_MIN && int'(load_value) <= C_MAX) begin
        m_count <= int'(load_value);
      end else begin
        m_count <= C_MIN;
        m_error <= 1'b1;
      end
    end else if (incr) begin
`ifdef C_INCR_CTR_SAT_EN
      m_count <= (m_count == C_MAX) ? C_MAX : m_count + 1;
      m_wrap  <= 1'b0;
`else
      m_count <= C_MIN + ((m_count - C_MIN + 1) % C_NUM);
      m_wrap  <= (m_count == C_MAX);
`endif
    end else begin
      m_wrap <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_count",  int'(count),  m_count);
    check("model_at_max", int'(at_max), int'(m_count == C_MAX));
    check("model_wrap",   int'(wrap),   int'(m_wrap));
    check("model_error",  int'(error),  int'(m_error));
  end

  initial begin
    int seq_cnt [5];
    int seq_wrp [5];
`ifdef C_INCR_CTR_SAT_EN
    seq_cnt = '{3, 4, 5, 6, 6};
    seq_wrp = '{0, 0, 0, 0, 0};
`else
    seq_cnt = '{3, 4, 5, 6, 2};
    seq_wrp = '{0, 0, 0, 0, 1};
`endif

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", int'(count), 2);
    check("rst_wrap", int'(wrap), 0);
    check("rst_at_max", int'(at_max), 0);
    check("rst_error", int'(error), 0);

    // Five consecutive increments across the top of the range
    incr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("seq_count", int'(count), seq_cnt[i]);
      check("seq_at_max", int'(at_max), int'(seq_cnt[i] == 6));
      check("seq_wrap", int'(wrap), seq_wrp[i]);
    end
    incr = 1'b0;

    // Load beats incr; inactive cycles hold
    load = 1'b1; load_value = 3'd5; incr = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("load_count", int'(count), 5);
    check("load_wrap", int'(wrap), 0);
    active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_count", int'(count), 5);
    end
    active = 1'b1; incr = 1'b0;

    // Out-of-range loads above and below the range
    load = 1'b1; load_value = 3'd7;
    @(negedge clk);
    check("oor_hi_count", int'(count), 2);
    check("oor_hi_error", int'(error), 1);
    load_value = 3'd1;
    @(negedge clk);
    check("oor_lo_count", int'(count), 2);
    check("oor_lo_error", int'(error), 1);
    load = 1'b0; incr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sticky_count", int'(count), 3 + i);
      check("sticky_error", int'(error), 1);
    end
    incr = 1'b0;

    // Asynchronous reset between edges with count at 4
    #2 rst = 1'b1;
    #1;
    check("arst_count", int'(count), 2);
    check("arst_error", int'(error), 0);
    check("arst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_count", int'(count), 2);
    check("arst_rel_wrap", int'(wrap), 0);

    // Load the top value, then keep incrementing
    load = 1'b1; load_value = 3'd6;
    @(negedge clk);
    load = 1'b0; incr = 1'b1;
    check("top_count", int'(count), 6);
    check("top_at_max", int'(at_max), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef C_INCR_CTR_SAT_EN
      check("sat_count", int'(count), 6);
      check("sat_at_max", int'(at_max), 1);
      check("sat_wrap", int'(wrap), 0);
`else
      check("top_inc_count", int'(count), 2 + i);
      check("top_inc_wrap", int'(wrap), int'(i == 0));
`endif
    end
    incr = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
